// File: rtl/mem_request_unit_if.sv
// Requester and shared-RAM signal bundle for mem_request_unit.
// slave is the unit's view; master is the requester/RAM environment's view.
interface mem_request_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_ren;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ren;
    logic              ram_wen;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;

    logic              err;

    modport slave (
        input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata, ram_ack,
        output i_rdata, i_ready, d_rdata, d_ready,
               ram_addr, ram_wdata, ram_ren, ram_wen, err
    );

    modport master (
        output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata, ram_ack,
        input  i_rdata, i_ready, d_rdata, d_ready,
               ram_addr, ram_wdata, ram_ren, ram_wen, err
    );
endinterface

// File: rtl/mem_request_unit.sv
// Arbitrates instruction fetch and data accesses onto one shared RAM port.
// Data wins over fetch; unacknowledged accesses abort after WAIT_LIMIT cycles.
module mem_request_unit #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic              clk,
    input  logic              nrst,
    mem_request_unit_if.slave bus
);
    localparam int unsigned       WAIT_W    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ren_q;
    logic              wen_q;
    logic              bad_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              i_ready_q;
    logic              d_ready_q;
    logic              err_q;
    logic [WAIT_W-1:0] wait_q;
    logic              timeout_hit;

    // The last unacked cycle of the budget aborts instead of counting on.
    assign timeout_hit = (WAIT_LIMIT != 0) && (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            bad_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
            wait_q    <= '0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.d_wen || bus.d_ren) begin
                        state_q <= DATA;
                        addr_q  <= bus.d_addr;
                        wdata_q <= bus.d_wdata;
                        wen_q   <= bus.d_wen;
                        ren_q   <= !bus.d_wen;
                        bad_q   <= bus.d_wen && bus.d_ren;
                        wait_q  <= '0;
                    end else if (bus.i_req) begin
                        state_q <= FETCH;
                        addr_q  <= bus.i_addr;
                        wen_q   <= 1'b0;
                        ren_q   <= 1'b1;
                        bad_q   <= 1'b0;
                        wait_q  <= '0;
                    end
                end
                FETCH, DATA: begin
                    if (bus.ram_ack || timeout_hit) begin
                        state_q <= RESP;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        err_q   <= bad_q || !bus.ram_ack;
                        if (state_q == DATA) begin
                            d_ready_q <= 1'b1;
                            if (ren_q) d_rdata_q <= bus.ram_ack ? bus.ram_rdata : '0;
                        end else begin
                            i_ready_q <= 1'b1;
                            i_rdata_q <= bus.ram_ack ? bus.ram_rdata : '0;
                        end
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_ren   = ren_q;
    assign bus.ram_wen   = wen_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_request_unit.sv
// Bench for mem_request_unit: vector table plus hand sequences for collision and reset,
// with a RAM model that checks strobes and a response scoreboard.
module tb_mem_request_unit;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned WL = 4;

    typedef struct {
        bit          is_data;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ram_value;
        int          ack_delay;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
        int          exp_len;
    } vec_t;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        bit          err;
    } resp_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    int          ack_delay = -1;
    bit          ack_force = 1'b0;
    logic [31:0] ram_value = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    bit          exp_wen = 1'b0;
    bit          strb_bad = 1'b0;
    int          strb_cnt = 0;
    int          last_len = 0;
    resp_t       sb[$];
    vec_t        vt[9];

    mem_request_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_request_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_LIMIT(WL)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // RAM model and response scoreboard, all sampled mid-cycle.
    always @(negedge clk) begin
        resp_t e;
        bus.ram_rdata = ram_value;
        if (bus.ram_ren || bus.ram_wen) begin
            if (bus.ram_ren && bus.ram_wen) strb_bad = 1'b1;
            if (bus.ram_addr !== exp_addr || bus.ram_wen !== exp_wen) strb_bad = 1'b1;
            if (exp_wen && bus.ram_wdata !== exp_wdata) strb_bad = 1'b1;
            bus.ram_ack = ack_force || (ack_delay >= 0 && strb_cnt == ack_delay);
            strb_cnt++;
        end else begin
            bus.ram_ack = ack_force;
            if (strb_cnt != 0) last_len = strb_cnt;
            strb_cnt = 0;
        end
        if (bus.i_ready || bus.d_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_ready: got i=%0b d=%0b want none", bus.i_ready, bus.d_ready);
            end else begin
                e = sb.pop_front();
                chk("rdy_kind", {bus.i_ready, bus.d_ready}, e.is_data ? 2'b01 : 2'b10);
                chk("rdata", e.is_data ? bus.d_rdata : bus.i_rdata, e.rdata);
                chk("err", bus.err, e.err);
            end
        end
    end

    task automatic wait_ready(input string name, input bit is_data, output int at);
        at = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (is_data ? bus.d_ready : bus.i_ready) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk({name, "_expired"}, 0, 1);
    endtask

    task automatic drop_all();
        bus.i_req = 1'b0;
        bus.d_ren = 1'b0;
        bus.d_wen = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int start, at;
        @(posedge clk); #1;
        exp_addr  = v.addr;
        exp_wdata = v.wdata;
        exp_wen   = v.wen;
        ack_delay = v.ack_delay;
        ram_value = v.ram_value;
        strb_bad  = 1'b0;
        sb.push_back('{v.is_data, v.exp_rdata, v.exp_err});
        if (v.is_data) begin
            bus.d_ren   = v.ren;
            bus.d_wen   = v.wen;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
        end else begin
            bus.i_req  = 1'b1;
            bus.i_addr = v.addr;
        end
        start = cyc;
        @(posedge clk); #1;
        // Requester inputs wander while the request stays asserted.
        bus.d_addr  = ~v.addr;
        bus.d_wdata = ~v.wdata;
        bus.i_addr  = ~v.addr;
        wait_ready($sformatf("v%0d", idx), v.is_data, at);
        chk($sformatf("v%0d_lat", idx), at - start, v.exp_lat);
        @(posedge clk); #1;
        drop_all();
        chk($sformatf("v%0d_len", idx), last_len, v.exp_len);
        chk($sformatf("v%0d_strobe", idx), strb_bad, 0);
    endtask

    initial begin
        int t0, td, tf, stray;
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, td, tf, stray;
        //        data ren  wen  addr         wdata        ram_value    dly  exp_rdata    err  lat len
        vt[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0050_0093, 0, 32'h0050_0093, 1'b0, 2, 1};
        vt[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h1122_3344, 1, 32'h1122_3344, 1'b0, 3, 2};
        vt[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h7777_7777, 3, 32'h1122_3344, 1'b0, 5, 4};
        vt[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 1'b0, 4, 3};
        vt[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h5555_5555, -1, 32'h0, 1'b1, 5, 4};
        vt[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_3000, 32'h1234_5678, 32'h9999_9999, 0, 32'h0, 1'b1, 2, 1};
        vt[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'hA5A5_A5A5, 3, 32'hA5A5_A5A5, 1'b0, 5, 4};
        vt[7] = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h3333_3333, -1, 32'h0, 1'b1, 5, 4};
        vt[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h1357_9BDF, 0, 32'h1357_9BDF, 1'b0, 2, 1};

        drop_all();
        bus.i_addr  = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {bus.i_ready, bus.d_ready, bus.err}, 3'b000);
        chk("rst_strobe", {bus.ram_ren, bus.ram_wen}, 2'b00);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_wdata", bus.ram_wdata, 0);
        chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
        nrst = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        // Fetch and data request together: data first, fetch follows.
        @(posedge clk); #1;
        exp_addr  = 32'h50;
        exp_wen   = 1'b0;
        ack_delay = 0;
        ram_value = 32'h0BAD_C0DE;
        strb_bad  = 1'b0;
        sb.push_back('{1'b1, 32'h0BAD_C0DE, 1'b0});
        sb.push_back('{1'b0, 32'h0BAD_C0DE, 1'b0});
        bus.d_ren  = 1'b1;
        bus.d_addr = 32'h50;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h300;
        t0 = cyc;
        wait_ready("coll_d", 1'b1, td);
        exp_addr = 32'h300;
        @(posedge clk); #1;
        bus.d_ren = 1'b0;
        wait_ready("coll_i", 1'b0, tf);
        @(posedge clk); #1;
        drop_all();
        chk("coll_d_lat", td - t0, 2);
        chk("coll_i_gap", tf - td, 3);
        chk("coll_strobe", strb_bad, 0);

        // Reset in the middle of a waiting data read.
        @(posedge clk); #1;
        exp_addr  = 32'h60;
        exp_wen   = 1'b0;
        ack_delay = -1;
        strb_bad  = 1'b0;
        bus.d_ren  = 1'b1;
        bus.d_addr = 32'h60;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_strobe_on", bus.ram_ren, 1);
        #2 nrst = 1'b0;
        #1;
        chk("mid_rst_strobe", {bus.ram_ren, bus.ram_wen}, 2'b00);
        chk("mid_rst_ready", {bus.i_ready, bus.d_ready, bus.err}, 3'b000);
        chk("mid_rst_rdata", bus.d_rdata, 0);
        drop_all();
        @(posedge clk); #1;
        nrst = 1'b1;
        ack_force = 1'b1;
        stray = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (bus.i_ready || bus.d_ready || bus.err || bus.ram_ren || bus.ram_wen) stray++;
        end
        @(posedge clk); #1;
        ack_force = 1'b0;
        chk("late_ack_ignored", stray, 0);

        run_vec(8, vt[8]);

        repeat (2) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_request_unit.md
MEM_REQUEST_UNIT -- requirements
Module: mem_request_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, width of all data ports.
REQ-003 SHALL have parameter WAIT_LIMIT, default 16, max RAM wait cycles before abort; 0 disables the timeout.
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk input 1, rising-edge clock; nrst input 1, async active-low reset.
REQ-005 SHALL have i_req input 1, instruction fetch request, held until i_ready.
REQ-006 SHALL have i_addr input ADDR_W, fetch address.
REQ-007 SHALL have i_rdata output DATA_W, fetched instruction.
REQ-008 SHALL have i_ready output 1, one-cycle fetch completion pulse.
REQ-009 SHALL have d_ren and d_wen inputs 1 each, data read and write requests, held until d_ready.
REQ-010 SHALL have d_addr input ADDR_W and d_wdata input DATA_W, data address and store data.
REQ-011 SHALL have d_rdata output DATA_W, load data, and d_ready output 1, one-cycle data completion pulse.
REQ-012 SHALL have ram_addr output ADDR_W, ram_wdata output DATA_W, ram_ren output 1, ram_wen output 1, shared RAM port strobes.
REQ-013 SHALL have ram_rdata input DATA_W, RAM read data, and ram_ack input 1, RAM completion, valid only while a strobe is high.
REQ-014 SHALL have err output 1, asserted with a ready pulse for a timed-out or malformed access.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, DATA, RESP; all outputs registered.
REQ-016 In IDLE, d_wen|d_ren SHALL move to DATA; otherwise i_req SHALL move to FETCH; otherwise remain IDLE.
REQ-017 Data SHALL take priority over fetch when both request in the same IDLE cycle; the fetch is served after the data access.
REQ-018 On leaving IDLE, address, store data and access type SHALL be latched; RAM outputs SHALL drive latched values only, insensitive to requester changes mid-access.
REQ-019 In FETCH, ram_ren=1 and ram_wen=0; in DATA, exactly one of ram_wen (d_wen) or ram_ren (d_ren only) SHALL be 1.
REQ-020 d_ren and d_wen both high SHALL be served as a write, with err=1 in its RESP cycle.
REQ-021 In FETCH/DATA, ram_ack=1 SHALL capture ram_rdata (reads) into i_rdata/d_rdata, drop strobes, and move to RESP on the next edge.
REQ-022 RESP SHALL last exactly one cycle with i_ready or d_ready high (matching the access), no strobes, then return to IDLE.
REQ-023 Requesters SHALL deassert or change their request on the edge where ready is sampled; the next request is accepted in the following IDLE cycle.
REQ-024 Minimum latency: request seen in IDLE at cycle 0, strobe at cycle 1, ack at cycle 1, ready at cycle 2.
REQ-025 A wait counter SHALL clear on entering FETCH/DATA and increment each cycle without ack; at WAIT_LIMIT (nonzero), abort to RESP with rdata=0 and err=1.
REQ-026 i_rdata/d_rdata SHALL hold their last value until the next completion of the same type; writes leave d_rdata unchanged.
REQ-027 Outputs other than ready, err and RAM strobes SHALL hold value when idle.

Reset
REQ-028 nrst low SHALL asynchronously force state IDLE, all strobes, ready pulses and err to 0, rdata and ram_addr/ram_wdata to 0, wait counter to 0.
REQ-029 Reset during FETCH/DATA SHALL abandon the access with no ready pulse; a late ram_ack after reset SHALL be ignored.

Verification
REQ-030 Fetch: i_req=1, i_addr=0x100, ram_ack on first strobe cycle with ram_rdata=0x00500093 -> i_ready at cycle 2, i_rdata=0x00500093, err=0.
REQ-031 Collision: i_req and d_ren same cycle -> DATA served first (d_ready), then FETCH (i_ready) exactly 2 cycles after RESP of data with ack-immediate RAM.
REQ-032 Store: d_wen=1, d_addr=0x2000, d_wdata=0xDEADBEEF, ack after 3 wait cycles -> ram_wen held 4 cycles with stable addr/data, d_ready one pulse, d_rdata unchanged.
REQ-033 Timeout: WAIT_LIMIT=4, ram_ack never -> strobe 4 cycles, d_ready=1 with err=1 and d_rdata=0, then IDLE.
REQ-034 Reset mid-access: nrst low during DATA wait -> strobes drop same cycle, no d_ready; after release, a fresh fetch completes normally.
REQ-035 Malformed: d_ren=d_wen=1 -> ram_wen only, d_ready with err=1.
